// File: rtl/cpl_write_pkg.sv
// Shared types and constants for the completion-write controller.
package cpl_write_pkg;

    // Controller states; one completion write is in flight at a time.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENQ_REQ  = 3'd1,
        ENQ_RESP = 3'd2,
        DMA_DESC = 3'd3,
        DMA_WAIT = 3'd4,
        COMMIT   = 3'd5,
        STATUS   = 3'd6
    } cpl_state_t;

    // Phase bit lives in bit 7 of the last byte of the completion record.
    localparam int unsigned PHASE_BIT_IN_BYTE = 7;

    // DMA status error code meaning success.
    localparam logic [3:0] DMA_ERR_NONE = 4'd0;

    // Absolute bit index of the phase bit inside a record of cpl_size bytes.
    function automatic int unsigned phase_bit_index(input int unsigned cpl_size);
        return (cpl_size - 1) * 8 + PHASE_BIT_IN_BYTE;
    endfunction

endpackage

// File: rtl/cpl_write_ctrl.sv
// Completion write controller: reserves a completion-queue slot, DMA-writes
// the record with the phase bit inserted, commits the op and reports status.
module cpl_write_ctrl
    import cpl_write_pkg::*;
#(
    parameter int unsigned QUEUE_INDEX_WIDTH   = 8,
    parameter int unsigned REQ_TAG_WIDTH       = 8,
    parameter int unsigned QUEUE_REQ_TAG_WIDTH = 8,
    parameter int unsigned QUEUE_OP_TAG_WIDTH  = 8,
    parameter int unsigned DMA_ADDR_WIDTH      = 64,
    parameter int unsigned DMA_LEN_WIDTH       = 16,
    parameter int unsigned DMA_TAG_WIDTH       = 8,
    parameter int unsigned CPL_SIZE            = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,

    input  logic [QUEUE_INDEX_WIDTH-1:0]   s_axis_req_queue,
    input  logic [REQ_TAG_WIDTH-1:0]       s_axis_req_tag,
    input  logic [CPL_SIZE*8-1:0]          s_axis_req_data,
    input  logic                           s_axis_req_valid,
    output logic                           s_axis_req_ready,

    output logic [REQ_TAG_WIDTH-1:0]       m_axis_req_status_tag,
    output logic                           m_axis_req_status_full,
    output logic                           m_axis_req_status_error,
    output logic                           m_axis_req_status_valid,

    output logic [QUEUE_INDEX_WIDTH-1:0]   m_axis_enqueue_req_queue,
    output logic [QUEUE_REQ_TAG_WIDTH-1:0] m_axis_enqueue_req_tag,
    output logic                           m_axis_enqueue_req_valid,
    input  logic                           m_axis_enqueue_req_ready,

    input  logic [DMA_ADDR_WIDTH-1:0]      s_axis_enqueue_resp_addr,
    input  logic                           s_axis_enqueue_resp_phase,
    input  logic [QUEUE_REQ_TAG_WIDTH-1:0] s_axis_enqueue_resp_tag,
    input  logic [QUEUE_OP_TAG_WIDTH-1:0]  s_axis_enqueue_resp_op_tag,
    input  logic                           s_axis_enqueue_resp_full,
    input  logic                           s_axis_enqueue_resp_error,
    input  logic                           s_axis_enqueue_resp_valid,
    output logic                           s_axis_enqueue_resp_ready,

    output logic [QUEUE_OP_TAG_WIDTH-1:0]  m_axis_enqueue_commit_op_tag,
    output logic                           m_axis_enqueue_commit_valid,
    input  logic                           m_axis_enqueue_commit_ready,

    output logic [DMA_ADDR_WIDTH-1:0]      m_axis_dma_write_desc_dma_addr,
    output logic [DMA_LEN_WIDTH-1:0]       m_axis_dma_write_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]       m_axis_dma_write_desc_tag,
    output logic [CPL_SIZE*8-1:0]          m_axis_dma_write_desc_data,
    output logic                           m_axis_dma_write_desc_valid,
    input  logic                           m_axis_dma_write_desc_ready,

    input  logic [DMA_TAG_WIDTH-1:0]       s_axis_dma_write_desc_status_tag,
    input  logic [3:0]                     s_axis_dma_write_desc_status_error,
    input  logic                           s_axis_dma_write_desc_status_valid
);

    localparam int unsigned CPL_W     = CPL_SIZE * 8;
    localparam int unsigned PHASE_IDX = phase_bit_index(CPL_SIZE);

    cpl_state_t r_state;
    cpl_state_t w_state_next;

    logic [QUEUE_INDEX_WIDTH-1:0]   r_queue;
    logic [REQ_TAG_WIDTH-1:0]       r_req_tag;
    logic [CPL_W-1:0]               r_data;
    logic [DMA_ADDR_WIDTH-1:0]      r_addr;
    logic [QUEUE_OP_TAG_WIDTH-1:0]  r_op_tag;
    logic                           r_full;
    logic                           r_error;
    logic [QUEUE_REQ_TAG_WIDTH-1:0] r_enq_tag_cnt;
    logic [QUEUE_REQ_TAG_WIDTH-1:0] r_enq_tag_issued;
    logic [DMA_TAG_WIDTH-1:0]       r_dma_tag_cnt;
    logic [DMA_TAG_WIDTH-1:0]       r_dma_tag_issued;

    logic w_req_hs;
    logic w_resp_match;
    logic w_resp_reject;
    logic w_dma_match;

    assign w_req_hs      = s_axis_req_valid && s_axis_req_ready;
    assign w_resp_match  = (r_state == ENQ_RESP) && s_axis_enqueue_resp_valid &&
                           (s_axis_enqueue_resp_tag == r_enq_tag_issued);
    assign w_resp_reject = s_axis_enqueue_resp_full || s_axis_enqueue_resp_error;
    assign w_dma_match   = (r_state == DMA_WAIT) && s_axis_dma_write_desc_status_valid &&
                           (s_axis_dma_write_desc_status_tag == r_dma_tag_issued);

    // Payload outputs come straight from the latched operation context.
    assign m_axis_req_status_tag          = r_req_tag;
    assign m_axis_req_status_full         = r_full;
    assign m_axis_req_status_error        = r_error;
    assign m_axis_enqueue_req_queue       = r_queue;
    assign m_axis_enqueue_req_tag         = r_enq_tag_cnt;
    assign m_axis_enqueue_commit_op_tag   = r_op_tag;
    assign m_axis_dma_write_desc_dma_addr = r_addr;
    assign m_axis_dma_write_desc_len      = DMA_LEN_WIDTH'(CPL_SIZE);
    assign m_axis_dma_write_desc_tag      = r_dma_tag_cnt;
    assign m_axis_dma_write_desc_data     = r_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        w_state_next                = r_state;
        s_axis_req_ready            = 1'b0;
        m_axis_enqueue_req_valid    = 1'b0;
        s_axis_enqueue_resp_ready   = 1'b0;
        m_axis_dma_write_desc_valid = 1'b0;
        m_axis_enqueue_commit_valid = 1'b0;
        m_axis_req_status_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is held low during reset so no request appears accepted.
                s_axis_req_ready = enable && !rst;
                if (s_axis_req_valid && enable && !rst) begin
                    w_state_next = ENQ_REQ;
                end
            end
            ENQ_REQ: begin
                m_axis_enqueue_req_valid = 1'b1;
                if (m_axis_enqueue_req_ready) begin
                    w_state_next = ENQ_RESP;
                end
            end
            ENQ_RESP: begin
                s_axis_enqueue_resp_ready = 1'b1;
                if (w_resp_match) begin
                    w_state_next = w_resp_reject ? STATUS : DMA_DESC;
                end
            end
            DMA_DESC: begin
                m_axis_dma_write_desc_valid = 1'b1;
                if (m_axis_dma_write_desc_ready) begin
                    w_state_next = DMA_WAIT;
                end
            end
            DMA_WAIT: begin
                if (w_dma_match) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                m_axis_enqueue_commit_valid = 1'b1;
                if (m_axis_enqueue_commit_ready) begin
                    w_state_next = STATUS;
                end
            end
            STATUS: begin
                m_axis_req_status_valid = 1'b1;
                w_state_next            = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operation context, status flags and tag counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_queue          <= '0;
            r_req_tag        <= '0;
            r_data           <= '0;
            r_addr           <= '0;
            r_op_tag         <= '0;
            r_full           <= 1'b0;
            r_error          <= 1'b0;
            r_enq_tag_cnt    <= '0;
            r_enq_tag_issued <= '0;
            r_dma_tag_cnt    <= '0;
            r_dma_tag_issued <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_hs) begin
                        r_queue   <= s_axis_req_queue;
                        r_req_tag <= s_axis_req_tag;
                        r_data    <= s_axis_req_data;
                        r_full    <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                ENQ_REQ: begin
                    if (m_axis_enqueue_req_ready) begin
                        r_enq_tag_issued <= r_enq_tag_cnt;
                        r_enq_tag_cnt    <= r_enq_tag_cnt + QUEUE_REQ_TAG_WIDTH'(1);
                    end
                end
                ENQ_RESP: begin
                    if (w_resp_match) begin
                        r_full  <= s_axis_enqueue_resp_full;
                        r_error <= s_axis_enqueue_resp_error;
                        if (!w_resp_reject) begin
                            r_addr            <= s_axis_enqueue_resp_addr;
                            r_op_tag          <= s_axis_enqueue_resp_op_tag;
                            r_data[PHASE_IDX] <= s_axis_enqueue_resp_phase;
                        end
                    end
                end
                DMA_DESC: begin
                    if (m_axis_dma_write_desc_ready) begin
                        r_dma_tag_issued <= r_dma_tag_cnt;
                        r_dma_tag_cnt    <= r_dma_tag_cnt + DMA_TAG_WIDTH'(1);
                    end
                end
                DMA_WAIT: begin
                    // Error is sticky; the commit still goes out to free the slot.
                    if (w_dma_match &&
                        (s_axis_dma_write_desc_status_error != DMA_ERR_NONE)) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpl_write_ctrl.sv
// Self-checking bench for cpl_write_ctrl: directed table, corner sequences
// and randomized operations against a transaction-level reference model.
module tb_cpl_write_ctrl;

    localparam int BUDGET = 60;

    typedef struct {
        logic [7:0]   queue;
        logic [7:0]   tag;
        logic [255:0] data;
        logic [63:0]  addr;
        logic         phase;
        logic [7:0]   op_tag;
        logic         full;
        logic         qerr;
        logic [3:0]   dma_err;
        int           stall_enq;
        int           stall_desc;
        int           stall_cmt;
        bit           stray_dma;
        bit           stray_resp;
        bit           en_off;
        bit           abort;
        logic         exp_full;
        logic         exp_err;
        bit           exp_dma;
        logic [7:0]   exp_last_byte;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [7:0]   req_queue, req_tag;
    logic [255:0] req_data;
    logic         req_valid, req_ready;
    logic [7:0]   st_tag;
    logic         st_full, st_error, st_valid;
    logic [7:0]   enq_queue, enq_tag;
    logic         enq_valid, enq_ready;
    logic [63:0]  resp_addr;
    logic         resp_phase;
    logic [7:0]   resp_tag, resp_op_tag;
    logic         resp_full, resp_error, resp_valid, resp_ready;
    logic [7:0]   cmt_op_tag;
    logic         cmt_valid, cmt_ready;
    logic [63:0]  desc_addr;
    logic [15:0]  desc_len;
    logic [7:0]   desc_tag;
    logic [255:0] desc_data;
    logic         desc_valid, desc_ready;
    logic [7:0]   dst_tag;
    logic [3:0]   dst_error;
    logic         dst_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: tag counters advance once per issued request.
    logic [7:0] m_enq_tag;
    logic [7:0] m_dma_tag;

    cpl_write_ctrl dut (
        .clk                                (clk),
        .rst                                (rst),
        .enable                             (enable),
        .s_axis_req_queue                   (req_queue),
        .s_axis_req_tag                     (req_tag),
        .s_axis_req_data                    (req_data),
        .s_axis_req_valid                   (req_valid),
        .s_axis_req_ready                   (req_ready),
        .m_axis_req_status_tag              (st_tag),
        .m_axis_req_status_full             (st_full),
        .m_axis_req_status_error            (st_error),
        .m_axis_req_status_valid            (st_valid),
        .m_axis_enqueue_req_queue           (enq_queue),
        .m_axis_enqueue_req_tag             (enq_tag),
        .m_axis_enqueue_req_valid           (enq_valid),
        .m_axis_enqueue_req_ready           (enq_ready),
        .s_axis_enqueue_resp_addr           (resp_addr),
        .s_axis_enqueue_resp_phase          (resp_phase),
        .s_axis_enqueue_resp_tag            (resp_tag),
        .s_axis_enqueue_resp_op_tag         (resp_op_tag),
        .s_axis_enqueue_resp_full           (resp_full),
        .s_axis_enqueue_resp_error          (resp_error),
        .s_axis_enqueue_resp_valid          (resp_valid),
        .s_axis_enqueue_resp_ready          (resp_ready),
        .m_axis_enqueue_commit_op_tag       (cmt_op_tag),
        .m_axis_enqueue_commit_valid        (cmt_valid),
        .m_axis_enqueue_commit_ready        (cmt_ready),
        .m_axis_dma_write_desc_dma_addr     (desc_addr),
        .m_axis_dma_write_desc_len          (desc_len),
        .m_axis_dma_write_desc_tag          (desc_tag),
        .m_axis_dma_write_desc_data         (desc_data),
        .m_axis_dma_write_desc_valid        (desc_valid),
        .m_axis_dma_write_desc_ready        (desc_ready),
        .s_axis_dma_write_desc_status_tag   (dst_tag),
        .s_axis_dma_write_desc_status_error (dst_error),
        .s_axis_dma_write_desc_status_valid (dst_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles (cycle %0d)", name, BUDGET, cyc);
        req_valid = 1'b0; enq_ready = 1'b0; resp_valid = 1'b0;
        desc_ready = 1'b0; cmt_ready = 1'b0; dst_valid = 1'b0;
    endtask

    function automatic vec_t base();
        vec_t v;
        v.queue = 8'h03; v.tag = 8'h11; v.data = '0; v.addr = 64'h1000;
        v.phase = 1'b1; v.op_tag = 8'h05; v.full = 1'b0; v.qerr = 1'b0;
        v.dma_err = 4'h0; v.stall_enq = 0; v.stall_desc = 0; v.stall_cmt = 0;
        v.stray_dma = 1'b0; v.stray_resp = 1'b0; v.en_off = 1'b0; v.abort = 1'b0;
        v.exp_full = 1'b0; v.exp_err = 1'b0; v.exp_dma = 1'b1; v.exp_last_byte = 8'h80;
        return v;
    endfunction

    // Transaction-level model: what the requester should see for one request.
    function automatic vec_t ref_expect(input vec_t v);
        vec_t r;
        r = v;
        r.exp_full      = v.full;
        r.exp_dma       = !(v.full || v.qerr);
        r.exp_err       = v.qerr || (r.exp_dma && (v.dma_err != 4'h0));
        r.exp_last_byte = r.exp_dma ? {v.phase, v.data[254:248]} : v.data[255:248];
        return r;
    endfunction

    // Plays requester, queue manager and DMA engine for one operation.
    // Entered and left just after a falling edge.
    task automatic run_op(input vec_t v);
        int n, stall, k_req;
        bit first;
        logic [7:0] s_q, s_etag, s_dtag;
        logic [63:0] s_addr;
        logic [255:0] s_data, exp_data;
        exp_data = {v.exp_last_byte, v.data[247:0]};
        s_q = '0; s_etag = '0; s_dtag = '0; s_addr = '0; s_data = '0;

        req_queue = v.queue; req_tag = v.tag; req_data = v.data; req_valid = 1'b1;
        n = 0;
        forever begin
            #1;
            if (req_ready) break;
            @(negedge clk);
            n++;
            if (n > BUDGET) begin timeout("req_accept"); return; end
        end
        k_req = cyc;

        @(negedge clk);
        req_valid = 1'b0;
        stall = v.stall_enq; first = 1'b1; n = 0;
        forever begin
            if (enq_valid) begin
                if (first) begin
                    check("enq_queue", enq_queue, v.queue);
                    check("enq_tag", enq_tag, m_enq_tag);
                    s_q = enq_queue; s_etag = enq_tag; first = 1'b0;
                end else begin
                    check("enq_stable", {enq_queue, enq_tag}, {s_q, s_etag});
                end
                if (stall == 0) begin enq_ready = 1'b1; break; end
                stall--;
            end
            n++;
            if (n > BUDGET) begin timeout("enq_req"); return; end
            @(negedge clk);
        end
        m_enq_tag = m_enq_tag + 8'd1;

        @(negedge clk);
        enq_ready = 1'b0;
        if (v.stray_resp) begin
            resp_tag = s_etag ^ 8'h5A; resp_full = 1'b1; resp_error = 1'b1;
            resp_addr = 64'hDEAD; resp_op_tag = 8'hEE; resp_phase = ~v.phase;
            resp_valid = 1'b1;
            n = 0;
            while (!resp_ready) begin
                @(negedge clk); n++;
                if (n > BUDGET) begin timeout("resp_stray"); return; end
            end
            @(negedge clk);
        end
        resp_tag = s_etag; resp_full = v.full; resp_error = v.qerr;
        resp_addr = v.addr; resp_op_tag = v.op_tag; resp_phase = v.phase;
        resp_valid = 1'b1;
        n = 0;
        while (!resp_ready) begin
            @(negedge clk); n++;
            if (n > BUDGET) begin timeout("resp"); return; end
        end

        @(negedge clk);
        resp_valid = 1'b0;
        if (!v.exp_dma) begin
            check("rej_status_valid", st_valid, 1'b1);
            check("rej_status_tag", st_tag, v.tag);
            check("rej_status_full", st_full, v.exp_full);
            check("rej_status_error", st_error, v.exp_err);
            check("rej_no_desc", desc_valid, 1'b0);
            check("rej_no_commit", cmt_valid, 1'b0);
            @(negedge clk);
            check("rej_pulse_end", st_valid, 1'b0);
            check("rej_no_desc_cmt", desc_valid || cmt_valid, 1'b0);
            return;
        end

        stall = v.stall_desc; first = 1'b1; n = 0;
        forever begin
            if (desc_valid) begin
                if (first) begin
                    check("desc_addr", desc_addr, v.addr);
                    check("desc_len", desc_len, 16'd32);
                    check("desc_tag", desc_tag, m_dma_tag);
                    check("desc_data", desc_data, exp_data);
                    s_addr = desc_addr; s_dtag = desc_tag; s_data = desc_data;
                    first = 1'b0;
                end else begin
                    check("desc_stable", {desc_addr, desc_tag, desc_len}, {s_addr, s_dtag, 16'd32});
                    check("desc_data_stable", desc_data, s_data);
                end
                if (stall == 0) begin desc_ready = 1'b1; break; end
                stall--;
            end
            n++;
            if (n > BUDGET) begin timeout("desc"); return; end
            @(negedge clk);
        end
        m_dma_tag = m_dma_tag + 8'd1;

        @(negedge clk);
        desc_ready = 1'b0;
        if (v.abort) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_valids", {enq_valid, resp_ready, desc_valid, cmt_valid, st_valid}, 5'b0);
            check("abort_req_ready", req_ready, 1'b0);
            check("abort_status", {st_tag, st_full, st_error}, 10'b0);
            rst = 1'b0;
            m_enq_tag = 8'd0;
            m_dma_tag = 8'd0;
            @(negedge clk);
            check("abort_no_commit", cmt_valid, 1'b0);
            return;
        end
        if (v.en_off) enable = 1'b0;
        if (v.stray_dma) begin
            dst_tag = s_dtag + 8'd1; dst_error = 4'hF; dst_valid = 1'b1;
            @(negedge clk);
            dst_valid = 1'b0;
            check("stray_dma_ignored", cmt_valid, 1'b0);
            @(negedge clk);
            check("stray_dma_waiting", cmt_valid, 1'b0);
        end
        dst_tag = s_dtag; dst_error = v.dma_err; dst_valid = 1'b1;

        @(negedge clk);
        dst_valid = 1'b0;
        stall = v.stall_cmt; first = 1'b1; n = 0;
        forever begin
            if (cmt_valid) begin
                check(first ? "commit_op_tag" : "commit_stable", cmt_op_tag, v.op_tag);
                first = 1'b0;
                if (stall == 0) begin cmt_ready = 1'b1; break; end
                stall--;
            end
            n++;
            if (n > BUDGET) begin timeout("commit"); return; end
            @(negedge clk);
        end

        @(negedge clk);
        cmt_ready = 1'b0;
        check("status_valid", st_valid, 1'b1);
        check("status_tag", st_tag, v.tag);
        check("status_full", st_full, v.exp_full);
        check("status_error", st_error, v.exp_err);
        if (v.stall_enq == 0 && v.stall_desc == 0 && v.stall_cmt == 0 &&
            !v.stray_dma && !v.stray_resp)
            check("req_to_status_cycles", 256'(cyc - k_req), 256'd6);
        @(negedge clk);
        check("status_pulse_end", st_valid, 1'b0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;

        rst = 1'b1; enable = 1'b1;
        req_queue = '0; req_tag = '0; req_data = '0; req_valid = 1'b0;
        enq_ready = 1'b0;
        resp_addr = '0; resp_phase = 1'b0; resp_tag = '0; resp_op_tag = '0;
        resp_full = 1'b0; resp_error = 1'b0; resp_valid = 1'b0;
        cmt_ready = 1'b0; desc_ready = 1'b0;
        dst_tag = '0; dst_error = '0; dst_valid = 1'b0;
        m_enq_tag = 8'd0; m_dma_tag = 8'd0;

        // Directed vectors with hand-derived expectations.
        tbl[0] = base();
        v = base(); v.full = 1'b1; v.exp_full = 1'b1; v.exp_dma = 1'b0; v.exp_last_byte = 8'h00;
        tbl[1] = v;
        v = base(); v.tag = 8'h12; v.data = '1; v.phase = 1'b0; v.addr = 64'h2000; v.op_tag = 8'h09;
        v.dma_err = 4'h3; v.exp_err = 1'b1; v.exp_last_byte = 8'h7F;
        tbl[2] = v;
        v = base(); v.tag = 8'h13; v.phase = 1'b0; v.stray_dma = 1'b1; v.exp_last_byte = 8'h00;
        tbl[3] = v;
        v = base(); v.tag = 8'h14; v.data[255:248] = 8'h12; v.addr = 64'hFFFF_0000_0000_1FE0;
        v.stall_enq = 5; v.stall_desc = 5; v.stall_cmt = 5; v.exp_last_byte = 8'h92;
        tbl[4] = v;
        v = base(); v.tag = 8'h15; v.qerr = 1'b1; v.exp_err = 1'b1; v.exp_dma = 1'b0;
        v.exp_last_byte = 8'h00;
        tbl[5] = v;
        v = base(); v.tag = 8'h16; v.data[255:248] = 8'h85; v.phase = 1'b0; v.stray_resp = 1'b1;
        v.op_tag = 8'hC3; v.exp_last_byte = 8'h05;
        tbl[6] = v;
        v = base(); v.tag = 8'h17; v.full = 1'b1; v.qerr = 1'b1; v.exp_full = 1'b1; v.exp_err = 1'b1;
        v.exp_dma = 1'b0; v.exp_last_byte = 8'h00;
        tbl[7] = v;

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_valids", {enq_valid, resp_ready, desc_valid, cmt_valid, st_valid}, 5'b0);
        check("reset_status", {st_tag, st_full, st_error}, 10'b0);
        check("reset_tags", {enq_tag, desc_tag}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Disabling in DMA_WAIT finishes the op but blocks the next request.
        v = base(); v.tag = 8'h21; v.en_off = 1'b1; v = ref_expect(v);
        run_op(v);
        req_queue = 8'h07; req_tag = 8'h22; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("disabled_req_ready", req_ready, 1'b0);
            check("disabled_no_enq", enq_valid, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        v = base(); v.queue = 8'h07; v.tag = 8'h22; v.phase = 1'b0; v = ref_expect(v);
        run_op(v);

        // Reset while waiting on the DMA, then tags restart from zero.
        v = base(); v.tag = 8'h31; v.abort = 1'b1;
        run_op(v);
        v = base(); v.tag = 8'h32; v = ref_expect(v);
        run_op(v);

        // Randomized operations; long enough for both tag counters to wrap.
        for (int i = 0; i < 330; i++) begin
            v = base();
            v.queue   = 8'($urandom());
            v.tag     = 8'($urandom());
            for (int w = 0; w < 8; w++) v.data[w*32 +: 32] = $urandom();
            v.addr    = {$urandom(), $urandom()};
            v.phase   = 1'($urandom());
            v.op_tag  = 8'($urandom());
            v.full    = ($urandom_range(0, 15) == 0);
            v.qerr    = ($urandom_range(0, 15) == 0);
            v.dma_err = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.stall_enq  = $urandom_range(0, 2);
            v.stall_desc = $urandom_range(0, 2);
            v.stall_cmt  = $urandom_range(0, 2);
            v.stray_dma  = ($urandom_range(0, 7) == 0);
            v.stray_resp = ($urandom_range(0, 7) == 0);
            v = ref_expect(v);
            run_op(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
